// File: rtl/spi_loader_seq.sv
// Sequences the SPI flash loader: init pulse, load-done wait with timeout, then a
// FIFO-to-RAM word copy throttled by destination ready; reports done, abort and timeout.
module spi_loader_seq #(
  parameter int ADDR_W    = 14,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_word_cnt,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_timeout,
  output logic              o_ldr_init,
  output logic              o_ldr_fill,
  input  logic              i_ldr_fifo_empty,
  input  logic              i_ldr_fifo_low,
  output logic              o_ldr_fifo_rd,
  input  logic [31:0]       i_ldr_fifo_dout,
  input  logic              i_ldr_load_done,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready
);

  localparam int TW = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam bit TO_EN = (TIMEOUT_W > 0);
  // Last counter value before the wait reaches 2**TIMEOUT_W-1 cycles.
  localparam logic [TW-1:0] TO_LAST = {TW{1'b1}} - TW'(1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_LD, S_XFER, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              init_q, init_d;
  logic              fill_q, fill_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              pop;
  logic              abort_hit;

  assign abort_hit = i_abort && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    wait_d     = wait_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cur_addr_d = i_base_addr;
          remain_d   = i_word_cnt;
          err_d      = 1'b0;
          state_d    = (i_word_cnt == '0) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        wait_d  = '0;
        state_d = S_WAIT_LD;
      end
      S_WAIT_LD: begin
        if (i_ldr_load_done) begin
          state_d = S_XFER;
        end else if (TO_EN && (wait_q == TO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_XFER: begin
        pop = !i_ldr_fifo_empty && i_mem_ready && (remain_q != '0);
        if (pop) begin
          addr_d     = cur_addr_q;
          wdata_d    = i_ldr_fifo_dout;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d   = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition, including last-word and timeout.
    if (abort_hit) begin
      state_d    = S_IDLE;
      pop        = 1'b0;
      cur_addr_d = cur_addr_q;
      remain_d   = remain_q;
      err_d      = err_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE) && !i_abort;
    init_d = (state_d == S_INIT);
    fill_d = (state_d == S_XFER) && i_ldr_fifo_low;
    we_d   = pop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
      fill_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      init_q     <= init_d;
      fill_q     <= fill_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err_timeout = err_q;
  assign o_ldr_init    = init_q;
  assign o_ldr_fill    = fill_q;
  assign o_ldr_fifo_rd = pop;
  assign o_mem_we      = we_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_spi_loader_seq.sv
// Bench for spi_loader_seq: random FIFO/ready/abort stimulus against a cycle-level
// job model, plus literal checks on the directed jobs.
module tb_spi_loader_seq;

  logic        clk;
  logic        resetn;
  logic        i_start;
  logic [13:0] i_base_addr;
  logic [15:0] i_word_cnt;
  logic        i_abort;
  logic        o_busy, o_done, o_err_timeout, o_ldr_init, o_ldr_fill;
  logic        i_ldr_fifo_empty, i_ldr_fifo_low, o_ldr_fifo_rd;
  logic [31:0] i_ldr_fifo_dout;
  logic        i_ldr_load_done;
  logic        o_mem_we;
  logic [13:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;

  spi_loader_seq #(.ADDR_W(14), .CNT_W(16), .TIMEOUT_W(4)) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_word_cnt(i_word_cnt), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
    .o_err_timeout(o_err_timeout), .o_ldr_init(o_ldr_init), .o_ldr_fill(o_ldr_fill),
    .i_ldr_fifo_empty(i_ldr_fifo_empty), .i_ldr_fifo_low(i_ldr_fifo_low),
    .o_ldr_fifo_rd(o_ldr_fifo_rd), .i_ldr_fifo_dout(i_ldr_fifo_dout),
    .i_ldr_load_done(i_ldr_load_done), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Loader FIFO contents for the current job; head advances on each DUT pop.
  logic [31:0] words [64];
  int nwords = 0;
  int head = 0;

  // Per-job observations.
  int n_we, n_done, n_init, n_rd;
  int done_cyc, init_cyc, err_cyc, start_cyc, abort_cyc, last_busy_cyc;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  int log_cyc [64];

  // Job model: phase 0 idle, 1 init, 2 wait-load, 3 transfer, 4 done.
  int ph = 0;
  int m_cnt = 0, idx = 0, wc = 0;
  logic [13:0] m_base = '0;
  logic m_err = 1'b0, m_done = 1'b0, m_we = 1'b0, m_low_d = 1'b0;
  logic [13:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;

  always @(negedge clk) begin
    logic exp_pop;
    cyc++;
    if (!resetn) begin
      ph = 0; m_err = 1'b0; m_done = 1'b0; m_we = 1'b0; m_low_d = 1'b0;
      m_waddr = '0; m_wdata = '0; idx = 0; m_cnt = 0;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_err", 32'(o_err_timeout), 0);
      chk("rst_init", 32'(o_ldr_init), 0);
      chk("rst_fill", 32'(o_ldr_fill), 0);
      chk("rst_we", 32'(o_mem_we), 0);
      chk("rst_rd", 32'(o_ldr_fifo_rd), 0);
      chk("rst_addr", 32'(o_mem_addr), 0);
      chk("rst_wdata", o_mem_wdata, 0);
    end else begin
      exp_pop = (ph == 3) && !i_ldr_fifo_empty && i_mem_ready && (idx < m_cnt) && !i_abort;
      chk("busy", 32'(o_busy), 32'(ph != 0));
      chk("done", 32'(o_done), 32'(m_done));
      chk("init", 32'(o_ldr_init), 32'(ph == 1));
      chk("err", 32'(o_err_timeout), 32'(m_err));
      chk("fill", 32'(o_ldr_fill), 32'((ph == 3) && m_low_d));
      chk("we", 32'(o_mem_we), 32'(m_we));
      chk("addr", 32'(o_mem_addr), 32'(m_waddr));
      chk("wdata", o_mem_wdata, m_wdata);
      chk("rd", 32'(o_ldr_fifo_rd), 32'(exp_pop));

      if (o_mem_we && n_we < 64) begin
        chk("order", o_mem_wdata, words[n_we]);
        log_addr[n_we] = 32'(o_mem_addr);
        log_data[n_we] = o_mem_wdata;
        log_cyc[n_we]  = cyc;
      end
      if (o_mem_we) n_we++;
      if (o_done) begin n_done++; done_cyc = cyc; end
      if (o_ldr_init) begin n_init++; init_cyc = cyc; end
      if (o_err_timeout && err_cyc < 0) err_cyc = cyc;
      if (o_ldr_fifo_rd) begin n_rd++; head++; end
      if (o_busy) last_busy_cyc = cyc;
      if (i_abort && ph != 0) abort_cyc = cyc;

      m_we = exp_pop;
      if (exp_pop) begin
        m_waddr = m_base + 14'(idx);
        m_wdata = i_ldr_fifo_dout;
        idx++;
      end
      m_low_d = i_ldr_fifo_low;
      m_done  = 1'b0;
      if (ph != 0 && i_abort) begin
        ph = 0;
      end else begin
        case (ph)
          0: if (i_start) begin
               m_base = i_base_addr; m_cnt = int'(i_word_cnt); idx = 0;
               m_err = 1'b0; start_cyc = cyc;
               ph = (m_cnt == 0) ? 4 : 1;
             end
          1: begin ph = 2; wc = 0; end
          2: begin
               wc++;
               if (i_ldr_load_done) ph = 3;
               else if (wc == 15) begin m_err = 1'b1; ph = 0; end
             end
          3: if (exp_pop && idx == m_cnt) ph = 4;
          4: begin m_done = 1'b1; ph = 0; end
          default: ph = 0;
        endcase
      end
    end
  end

  // Stimulus configuration for the running job.
  int cfg_ld, cfg_rdy, cfg_gap, cfg_abort_pop;
  bit cfg_rand_abort, cfg_noise;

  task automatic job_clear();
    n_we = 0; n_done = 0; n_init = 0; n_rd = 0; head = 0;
    done_cyc = -1; init_cyc = -1; err_cyc = -1; start_cyc = -1;
    abort_cyc = -1; last_busy_cyc = -1;
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_abort = 1'b0; i_ldr_load_done = 1'b0;
    i_ldr_fifo_empty = 1'b1; i_ldr_fifo_low = 1'b0; i_mem_ready = 1'b0;
    i_ldr_fifo_dout = 32'h0;
  endtask

  task automatic drive(input int jc);
    logic gap;
    i_start = cfg_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (cfg_noise) begin
      i_base_addr = 14'($urandom);
      i_word_cnt  = 16'($urandom);
    end
    i_ldr_load_done = (jc >= cfg_ld);
    case (cfg_rdy)
      0:       i_mem_ready = 1'b1;
      1:       i_mem_ready = 1'(jc & 1);
      default: i_mem_ready = 1'($urandom_range(0, 1));
    endcase
    gap = ($urandom_range(0, 99) < cfg_gap);
    i_ldr_fifo_empty = (head >= nwords) || gap;
    i_ldr_fifo_dout  = (head < nwords) ? words[head] : 32'hDEAD_BEEF;
    i_ldr_fifo_low   = 1'($urandom_range(0, 1));
    i_abort = 1'b0;
    if (cfg_abort_pop > 0 && head == cfg_abort_pop - 1 && !i_ldr_fifo_empty && i_mem_ready)
      i_abort = 1'b1;
    if (cfg_rand_abort && $urandom_range(0, 24) == 0) i_abort = 1'b1;
  endtask

  task automatic run_job(input logic [13:0] base, input int cnt, input logic [31:0] seq,
                         input bit start_abort);
    bit finished;
    job_clear();
    nwords = cnt;
    for (int k = 0; k < 64; k++) words[k] = (seq != 0) ? seq + 32'(k) : $urandom;
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = base; i_word_cnt = 16'(cnt); i_abort = start_abort;
    i_ldr_load_done = 1'b0; i_ldr_fifo_empty = 1'b1;
    finished = 1'b0;
    for (int jc = 1; jc <= 400; jc++) begin
      @(posedge clk); #1;
      if (!o_busy) begin finished = 1'b1; break; end
      drive(jc);
    end
    idle_inputs();
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL job_timeout: job base 0x%0h cnt %0d never returned idle", base, cnt);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    i_base_addr = '0; i_word_cnt = '0;
    idle_inputs();
    cfg_ld = 1; cfg_rdy = 0; cfg_gap = 0; cfg_abort_pop = 0;
    cfg_rand_abort = 1'b0; cfg_noise = 1'b0;
    job_clear();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk); #1;
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_we", 32'(o_mem_we), 0);
    chk("reset_err", 32'(o_err_timeout), 0);

    // Load-done never arrives: timeout 16 cycles after the init pulse, no done.
    cfg_ld = 100000;
    run_job(14'h050, 5, 0, 1'b0);
    chk("t4_err_set", 32'(o_err_timeout), 1);
    chk("t4_err_latency", 32'(err_cyc - init_cyc), 16);
    chk("t4_no_done", 32'(n_done), 0);
    chk("t4_no_pop", 32'(n_rd), 0);

    // Back-to-back copy; this start also clears the sticky timeout.
    cfg_ld = 10;
    run_job(14'h100, 4, 32'hA0, 1'b0);
    chk("t1_err_cleared", 32'(o_err_timeout), 0);
    chk("t1_writes", 32'(n_we), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr", log_addr[k], 32'h100 + 32'(k));
      chk("t1_data", log_data[k], 32'hA0 + 32'(k));
    end
    chk("t1_consecutive", 32'(log_cyc[3] - log_cyc[0]), 3);
    chk("t1_done_after_last", 32'(done_cyc - log_cyc[3]), 1);
    chk("t1_done_count", 32'(n_done), 1);

    // Zero-length job, with abort raised alongside the start.
    run_job(14'h020, 0, 0, 1'b1);
    chk("t2_done_count", 32'(n_done), 1);
    chk("t2_done_latency", 32'(done_cyc - start_cyc), 2);
    chk("t2_no_init", 32'(n_init), 0);
    chk("t2_no_we", 32'(n_we), 0);
    chk("t2_no_rd", 32'(n_rd), 0);

    // Ready toggling and random FIFO gaps.
    cfg_ld = 4; cfg_rdy = 1; cfg_gap = 30;
    run_job(14'h200, 8, 0, 1'b0);
    chk("t3_writes", 32'(n_we), 8);
    chk("t3_done_count", 32'(n_done), 1);

    // Abort on the third pop.
    cfg_rdy = 0; cfg_gap = 0; cfg_abort_pop = 3;
    run_job(14'h300, 6, 0, 1'b0);
    chk("t5_writes", 32'(n_we), 2);
    chk("t5_no_done", 32'(n_done), 0);
    chk("t5_idle_next", 32'(last_busy_cyc), 32'(abort_cyc));
    cfg_abort_pop = 0;

    // Address wrap.
    run_job(14'h3FFE, 3, 0, 1'b0);
    chk("t6_writes", 32'(n_we), 3);
    chk("t6_addr0", log_addr[0], 32'h3FFE);
    chk("t6_addr1", log_addr[1], 32'h3FFF);
    chk("t6_addr2", log_addr[2], 32'h0000);

    // Reset asserted mid-transfer clears every output at once.
    begin
      bit reached;
      job_clear();
      nwords = 20;
      for (int k = 0; k < 64; k++) words[k] = $urandom;
      @(posedge clk); #1;
      i_start = 1'b1; i_base_addr = 14'h0; i_word_cnt = 16'd20;
      reached = 1'b0;
      for (int jc = 1; jc <= 100; jc++) begin
        @(posedge clk); #1;
        drive(jc);
        if (n_we >= 2) begin reached = 1'b1; break; end
      end
      chk("t6_reached_xfer", 32'(reached), 1);
      #1 resetn = 1'b0;
      #1;
      chk("t6_async_busy", 32'(o_busy), 0);
      chk("t6_async_we", 32'(o_mem_we), 0);
      chk("t6_async_addr", 32'(o_mem_addr), 0);
      chk("t6_async_wdata", o_mem_wdata, 0);
      chk("t6_async_rd", 32'(o_ldr_fifo_rd), 0);
      chk("t6_async_fill", 32'(o_ldr_fill), 0);
      idle_inputs();
      @(negedge clk);
      @(posedge clk); #1 resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      run_job(14'h040, 3, 0, 1'b0);
      chk("t6_reinit", 32'(n_init), 1);
      chk("t6_post_reset_writes", 32'(n_we), 3);
    end

    // Random jobs with noisy start/base/count inputs and occasional aborts.
    for (int j = 0; j < 10; j++) begin
      cfg_ld = $urandom_range(1, 13);
      cfg_rdy = $urandom_range(0, 2);
      cfg_gap = $urandom_range(0, 50);
      cfg_rand_abort = (j % 3 == 2);
      cfg_noise = 1'b1;
      run_job(14'($urandom), $urandom_range(0, 12), 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
